// File: rtl/alarm_pkg.sv
// Shared key codes, digit limits and state encoding
// for the alarm time setter slice.
package alarm_pkg;

    localparam logic [3:0] KEY_SET      = 4'hA;
    localparam logic [3:0] KEY_CANCEL   = 4'hB;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] H10_MAX      = 4'd2;
    localparam logic [3:0] H1_MAX_AT_20 = 4'd3;
    localparam logic [3:0] M10_MAX      = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EDIT    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_RINGING = 2'd3
    } state_t;

    // {alarm_en, editing, ring} as seen while sitting in a state
    function automatic logic [2:0] st_flags(input state_t s);
        logic [2:0] f;
        f = 3'b000;
        unique case (s)
            ST_IDLE:    f = 3'b000;
            ST_EDIT:    f = 3'b010;
            ST_ARMED:   f = 3'b100;
            ST_RINGING: f = 3'b101;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alarm_digit_validator.sv
// Range check for one keyed digit at the current edit position,
// plus the H1 fix-up needed when H10 becomes 2.
module alarm_digit_validator
    import alarm_pkg::*;
(
    input  logic [1:0] EDIT_POS,
    input  logic [3:0] DIGIT,
    input  logic [3:0] SH_H10,
    input  logic [3:0] SH_H1,
    output logic       VALID,
    output logic       H1_CLR
);

    always_comb begin
        VALID  = 1'b0;
        H1_CLR = 1'b0;
        unique case (EDIT_POS)
            2'd0: begin
                VALID  = (DIGIT <= H10_MAX);
                H1_CLR = (DIGIT == H10_MAX) && (SH_H1 > H1_MAX_AT_20);
            end
            2'd1: begin
                if (SH_H10 == H10_MAX)
                    VALID = (DIGIT <= H1_MAX_AT_20);
                else
                    VALID = (DIGIT <= DIGIT_MAX);
            end
            2'd2: VALID = (DIGIT <= M10_MAX);
            2'd3: VALID = (DIGIT <= DIGIT_MAX);
        endcase
    end

endmodule

// File: rtl/alarm_time_setter.sv
// Keypad editor for the HH:MM alarm, commit registers,
// and ring request on a match with the running clock.
module alarm_time_setter
    import alarm_pkg::*;
#(
    parameter logic [31:0] RING_CYCLES  = 32'd50_000_000,
    parameter logic [31:0] EDIT_TIMEOUT = 32'd500_000_000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_CODE,
    input  logic [3:0] T_H10,
    input  logic [3:0] T_H1,
    input  logic [3:0] T_M10,
    input  logic [3:0] T_M1,
    input  logic [3:0] T_S10,
    input  logic [3:0] T_S1,
    output logic [3:0] A_H10,
    output logic [3:0] A_H1,
    output logic [3:0] A_M10,
    output logic [3:0] A_M1,
    output logic       ALARM_EN,
    output logic       EDITING,
    output logic [1:0] EDIT_POS,
    output logic       ERR,
    output logic       RING
);

    state_t      state;
    state_t      ret_state;
    logic [3:0]  shadow [4];
    logic [31:0] edit_cnt;
    logic [31:0] ring_cnt;
    logic        match_prev;
    logic        match;
    logic        is_digit;
    logic        dig_ok;
    logic        h1_clr;

    assign match = (T_H10 == A_H10) && (T_H1 == A_H1) &&
                   (T_M10 == A_M10) && (T_M1 == A_M1) &&
                   (T_S10 == 4'd0) && (T_S1 == 4'd0);

    assign is_digit = (KEY_CODE <= DIGIT_MAX);

    alarm_digit_validator u_val (
        .EDIT_POS (EDIT_POS),
        .DIGIT    (KEY_CODE),
        .SH_H10   (shadow[0]),
        .SH_H1    (shadow[1]),
        .VALID    (dig_ok),
        .H1_CLR   (h1_clr)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            ret_state  <= ST_IDLE;
            A_H10      <= '0;
            A_H1       <= '0;
            A_M10      <= '0;
            A_M1       <= '0;
            shadow     <= '{default: '0};
            EDIT_POS   <= '0;
            edit_cnt   <= '0;
            ring_cnt   <= '0;
            match_prev <= 1'b0;
            ERR        <= 1'b0;
            {ALARM_EN, EDITING, RING} <= 3'b000;
        end else begin
            ERR        <= 1'b0;
            match_prev <= match;
            unique case (state)
                ST_IDLE, ST_ARMED: begin
                    if (KEY_VALID && KEY_CODE == KEY_SET) begin
                        state     <= ST_EDIT;
                        ret_state <= state;
                        shadow    <= '{A_H10, A_H1, A_M10, A_M1};
                        EDIT_POS  <= 2'd0;
                        edit_cnt  <= EDIT_TIMEOUT - 32'd1;
                        {ALARM_EN, EDITING, RING} <= st_flags(ST_EDIT);
                    end else if (state == ST_ARMED) begin
                        // a key strobe masks a coincident match edge
                        if (KEY_VALID) begin
                            if (KEY_CODE == KEY_CANCEL) begin
                                state <= ST_IDLE;
                                {ALARM_EN, EDITING, RING} <= st_flags(ST_IDLE);
                            end
                        end else if (match && !match_prev) begin
                            state    <= ST_RINGING;
                            ring_cnt <= RING_CYCLES - 32'd1;
                            {ALARM_EN, EDITING, RING} <= st_flags(ST_RINGING);
                        end
                    end
                end
                ST_EDIT: begin
                    if (KEY_VALID) begin
                        edit_cnt <= EDIT_TIMEOUT - 32'd1;
                        if (is_digit) begin
                            if (!dig_ok) begin
                                ERR <= 1'b1;
                            end else if (EDIT_POS == 2'd3) begin
                                A_H10    <= shadow[0];
                                A_H1     <= shadow[1];
                                A_M10    <= shadow[2];
                                A_M1     <= KEY_CODE;
                                state    <= ST_ARMED;
                                EDIT_POS <= 2'd0;
                                {ALARM_EN, EDITING, RING} <= st_flags(ST_ARMED);
                            end else begin
                                shadow[EDIT_POS] <= KEY_CODE;
                                if (h1_clr)
                                    shadow[1] <= 4'd0;
                                EDIT_POS <= EDIT_POS + 2'd1;
                            end
                        end else if (KEY_CODE == KEY_CANCEL) begin
                            state    <= ret_state;
                            EDIT_POS <= 2'd0;
                            {ALARM_EN, EDITING, RING} <= st_flags(ret_state);
                        end
                    end else if (edit_cnt == 32'd0) begin
                        state    <= ret_state;
                        EDIT_POS <= 2'd0;
                        {ALARM_EN, EDITING, RING} <= st_flags(ret_state);
                    end else begin
                        edit_cnt <= edit_cnt - 32'd1;
                    end
                end
                ST_RINGING: begin
                    if (KEY_VALID || ring_cnt == 32'd0) begin
                        state <= ST_ARMED;
                        {ALARM_EN, EDITING, RING} <= st_flags(ST_ARMED);
                    end else begin
                        ring_cnt <= ring_cnt - 32'd1;
                    end
                end
            endcase
        end
    end

endmodule
